// File: rtl/pspin_cluster_boot_seq_pkg.sv
// Shared definitions for the PsPIN cluster boot sequencer.
// The BOOT_ST_* codes are also what the control registers decode on state_o readback.
package pspin_cluster_boot_seq_pkg;

    localparam logic [2:0] BOOT_ST_IDLE    = 3'd0;
    localparam logic [2:0] BOOT_ST_RESET   = 3'd1;
    localparam logic [2:0] BOOT_ST_RELEASE = 3'd2;
    localparam logic [2:0] BOOT_ST_FETCH   = 3'd3;
    localparam logic [2:0] BOOT_ST_RUN     = 3'd4;
    localparam logic [2:0] BOOT_ST_DRAIN   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = BOOT_ST_IDLE,
        ST_RESET   = BOOT_ST_RESET,
        ST_RELEASE = BOOT_ST_RELEASE,
        ST_FETCH   = BOOT_ST_FETCH,
        ST_RUN     = BOOT_ST_RUN,
        ST_DRAIN   = BOOT_ST_DRAIN
    } boot_state_e;

    // Largest of four cycle counts; sizes the shared phase counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pspin_cluster_boot_seq.sv
// PsPIN cluster bring-up / shutdown sequencer.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | clusters held in aux reset, waiting for a start with mask!=0
// RESET   | aux reset asserted for RST_CYCLES
// RELEASE | aux reset released, settling for SETTLE_CYCLES
// FETCH   | walking idx over clusters, enabling masked ones with a stagger
// RUN     | all selected clusters fetching; wait for stop or all-EOC
// DRAIN   | fetch disabled, waiting for busy to drop or for the timeout
module pspin_cluster_boot_seq
    import pspin_cluster_boot_seq_pkg::*;
#(
    parameter int NUM_CLUSTERS   = 2,
    parameter int RST_CYCLES     = 16,
    parameter int SETTLE_CYCLES  = 8,
    parameter int STAGGER_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic [NUM_CLUSTERS-1:0] cl_mask_i,
    input  logic [NUM_CLUSTERS-1:0] cl_eoc_i,
    input  logic [NUM_CLUSTERS-1:0] cl_busy_i,
    output logic                    aux_rst_o,
    output logic [NUM_CLUSTERS-1:0] cl_fetch_en_o,
    output logic [2:0]              state_o,
    output logic                    running_o,
    output logic                    err_timeout_o,
    output logic [31:0]             drain_cycles_o
);

    localparam int CNT_W = $clog2(max4(RST_CYCLES, SETTLE_CYCLES,
                                       STAGGER_CYCLES, TIMEOUT_CYCLES)) + 1;
    localparam int IDX_W = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_RST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SETTLE  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_STAGGER = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_CLUSTERS - 1);
    localparam logic [31:0]      DRAIN_MAX   = '1;

    boot_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d, idx_inc;
    logic [NUM_CLUSTERS-1:0] mask_q, mask_d;
    logic                    aux_rst_q, aux_rst_d;
    logic [NUM_CLUSTERS-1:0] fetch_en_q, fetch_en_d;
    logic                    running_q, running_d;
    logic                    err_q, err_d;
    logic [31:0]             drain_q, drain_d;
    logic                    enter_drain;

    // State, counter and all output registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            mask_q     <= '0;
            aux_rst_q  <= 1'b1;
            fetch_en_q <= '0;
            running_q  <= 1'b0;
            err_q      <= 1'b0;
            drain_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            mask_q     <= mask_d;
            aux_rst_q  <= aux_rst_d;
            fetch_en_q <= fetch_en_d;
            running_q  <= running_d;
            err_q      <= err_d;
            drain_q    <= drain_d;
        end
    end

    // Next-state and next-output logic; each phase loads N-1 and moves on when the counter reads 0.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        aux_rst_d   = aux_rst_q;
        fetch_en_d  = fetch_en_q;
        err_d       = err_q;
        drain_d     = drain_q;
        enter_drain = 1'b0;
        idx_inc     = idx_q + IDX_W'(1);

        case (state_q)
            ST_IDLE: begin
                aux_rst_d  = 1'b1;
                fetch_en_d = '0;
                if (start_i && !stop_i && (cl_mask_i != '0)) begin
                    state_d = ST_RESET;
                    cnt_d   = CNT_RST;
                    mask_d  = cl_mask_i;
                    err_d   = 1'b0;
                    drain_d = '0;
                end
            end
            ST_RESET: begin
                if (stop_i) begin
                    enter_drain = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d   = ST_RELEASE;
                    cnt_d     = CNT_SETTLE;
                    aux_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (stop_i) begin
                    enter_drain = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d       = ST_FETCH;
                    idx_d         = '0;
                    fetch_en_d[0] = mask_q[0];
                    cnt_d         = mask_q[0] ? CNT_STAGGER : '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_FETCH: begin
                if (stop_i) begin
                    enter_drain = 1'b1;
                end else if (cnt_q == '0) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        idx_d               = idx_inc;
                        fetch_en_d[idx_inc] = mask_q[idx_inc];
                        cnt_d               = mask_q[idx_inc] ? CNT_STAGGER : '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RUN: begin
                if (stop_i || ((cl_eoc_i & mask_q) == mask_q)) begin
                    enter_drain = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q != DRAIN_MAX) begin
                    drain_d = drain_q + 32'd1;
                end
                if ((cl_busy_i & mask_q) == '0) begin
                    state_d   = ST_IDLE;
                    aux_rst_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d   = ST_IDLE;
                    aux_rst_d = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                aux_rst_d  = 1'b1;
                fetch_en_d = '0;
            end
        endcase

        // aux_rst is deliberately left alone: an abort from RESET keeps the clusters in reset.
        if (enter_drain) begin
            state_d    = ST_DRAIN;
            fetch_en_d = '0;
            cnt_d      = CNT_TIMEOUT;
            drain_d    = '0;
        end

        running_d = (state_d == ST_RUN);
    end

    assign state_o        = state_q;
    assign aux_rst_o      = aux_rst_q;
    assign cl_fetch_en_o  = fetch_en_q;
    assign running_o      = running_q;
    assign err_timeout_o  = err_q;
    assign drain_cycles_o = drain_q;

endmodule

// File: tb/tb_pspin_cluster_boot_seq.sv
// Self-checking bench for pspin_cluster_boot_seq: a timeline model checked every cycle,
// directed scenarios with literal timing pins, then randomized traffic.
module tb_pspin_cluster_boot_seq;

    localparam int NC      = 2;
    localparam int RST     = 16;
    localparam int SETTLE  = 8;
    localparam int STAG    = 4;
    localparam int TIMEOUT = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic [NC-1:0] cl_mask_i = '0;
    logic [NC-1:0] cl_eoc_i = '0;
    logic [NC-1:0] cl_busy_i = '0;
    logic          aux_rst_o;
    logic [NC-1:0] cl_fetch_en_o;
    logic [2:0]    state_o;
    logic          running_o;
    logic          err_timeout_o;
    logic [31:0]   drain_cycles_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    // Model state: phase number, elapsed boot time, drain length.
    int            m_st = 0;
    int            m_e = 0;
    int            m_k = 0;
    logic          m_aux = 1'b1;
    logic          m_err = 1'b0;
    logic [NC-1:0] m_fen = '0;
    logic [NC-1:0] m_mask = '0;
    logic [31:0]   m_drain = '0;

    pspin_cluster_boot_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .cl_mask_i      (cl_mask_i),
        .cl_eoc_i       (cl_eoc_i),
        .cl_busy_i      (cl_busy_i),
        .aux_rst_o      (aux_rst_o),
        .cl_fetch_en_o  (cl_fetch_en_o),
        .state_o        (state_o),
        .running_o      (running_o),
        .err_timeout_o  (err_timeout_o),
        .drain_cycles_o (drain_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Time (cycles after the start edge) at which cluster i's fetch slot begins;
    // i == NC gives the time RUN is reached.
    function automatic int slot_time(input logic [NC-1:0] msk, input int i);
        int t;
        t = RST + SETTLE + 1;
        for (int j = 0; j < i; j++) t += msk[j] ? STAG : 1;
        return t;
    endfunction

    task automatic boot_view();
        if (m_e <= RST) begin
            m_st = 1; m_aux = 1'b1;
        end else if (m_e <= RST + SETTLE) begin
            m_st = 2; m_aux = 1'b0;
        end else if (m_e < slot_time(m_mask, NC)) begin
            m_st = 3; m_aux = 1'b0;
        end else begin
            m_st = 4; m_aux = 1'b0;
        end
        m_fen = '0;
        for (int i = 0; i < NC; i++)
            if (m_mask[i] && m_e >= slot_time(m_mask, i)) m_fen[i] = 1'b1;
    endtask

    task automatic go_drain();
        m_st = 5; m_fen = '0; m_k = 0; m_drain = '0;
    endtask

    task automatic to_idle();
        m_st = 0; m_aux = 1'b1; m_fen = '0;
    endtask

    task automatic model_step();
        cyc++;
        if (!rst_n) begin
            m_st = 0; m_aux = 1'b1; m_fen = '0; m_err = 1'b0; m_drain = '0; m_e = 0; m_k = 0;
            return;
        end
        case (m_st)
            0: begin
                if (start_i && !stop_i && cl_mask_i != '0) begin
                    m_mask = cl_mask_i; m_err = 1'b0; m_drain = '0; m_e = 1;
                    boot_view();
                end
            end
            1, 2, 3: begin
                if (stop_i) go_drain();
                else begin
                    m_e++;
                    boot_view();
                end
            end
            4: if (stop_i || (cl_eoc_i & m_mask) == m_mask) go_drain();
            5: begin
                if (m_drain != 32'hFFFF_FFFF) m_drain++;
                m_k++;
                if ((cl_busy_i & m_mask) == '0) to_idle();
                else if (m_k >= TIMEOUT) begin
                    m_err = 1'b1;
                    to_idle();
                end
            end
            default: to_idle();
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("m_state", 32'(state_o), 32'(m_st));
            chk("m_aux_rst", 32'(aux_rst_o), 32'(m_aux));
            chk("m_fetch_en", 32'(cl_fetch_en_o), 32'(m_fen));
            chk("m_running", 32'(running_o), 32'(m_st == 4));
            chk("m_err", 32'(err_timeout_o), 32'(m_err));
            chk("m_drain", drain_cycles_o, m_drain);
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    // Start a boot with the given mask and follow it to RUN.
    task automatic boot_to_run(input logic [NC-1:0] msk);
        cl_mask_i = msk; start_i = 1'b1;
        nxt();
        start_i = 1'b0;
        repeat (slot_time(msk, NC) - 1) nxt();
        chk("boot_run_state", 32'(state_o), 32'd4);
    endtask

    int  n;
    bit  done;

    initial begin
        repeat (3) nxt();
        cmp_en = 1'b1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_aux", 32'(aux_rst_o), 32'd1);
        chk("rst_fen", 32'(cl_fetch_en_o), 32'd0);
        chk("rst_run", 32'(running_o), 32'd0);
        chk("rst_err", 32'(err_timeout_o), 32'd0);
        chk("rst_drain", drain_cycles_o, 32'd0);
        rst_n = 1'b1;
        repeat (2) nxt();

        // Scenario 1: mask 11, literal timing pins relative to the start cycle T.
        cl_mask_i = 2'b11; start_i = 1'b1;
        for (int j = 1; j <= 33; j++) begin
            nxt();
            if (j == 1) begin
                start_i = 1'b0;
                chk("t1_state_reset", 32'(state_o), 32'd1);
            end
            if (j == 16) chk("t1_aux_hi", 32'(aux_rst_o), 32'd1);
            if (j == 17) chk("t1_aux_lo", 32'(aux_rst_o), 32'd0);
            if (j == 24) chk("t1_fen_pre", 32'(cl_fetch_en_o), 32'd0);
            if (j == 25) chk("t1_fen0", 32'(cl_fetch_en_o), 32'd1);
            if (j == 28) chk("t1_fen0_hold", 32'(cl_fetch_en_o), 32'd1);
            if (j == 29) chk("t1_fen1", 32'(cl_fetch_en_o), 32'd3);
            if (j == 32) chk("t1_run_pre", 32'(running_o), 32'd0);
            if (j == 33) chk("t1_run", 32'(running_o), 32'd1);
        end

        // Scenario 3: all-EOC with idle clusters drains in one cycle.
        cl_eoc_i = 2'b11; cl_busy_i = 2'b00;
        nxt();
        cl_eoc_i = 2'b00;
        chk("t3_drain", 32'(state_o), 32'd5);
        chk("t3_drain_fen", 32'(cl_fetch_en_o), 32'd0);
        nxt();
        chk("t3_idle", 32'(state_o), 32'd0);
        chk("t3_dcyc", drain_cycles_o, 32'd1);
        chk("t3_err", 32'(err_timeout_o), 32'd0);
        chk("t3_aux", 32'(aux_rst_o), 32'd1);
        nxt();

        // Scenario 2: mask 10 skips cluster 0 in a single cycle.
        cl_mask_i = 2'b10; start_i = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            nxt();
            if (j == 1) start_i = 1'b0;
            if (cl_fetch_en_o[0] !== 1'b0) chk("t2_fen0_zero", 32'(cl_fetch_en_o[0]), 32'd0);
            if (j == 25) chk("t2_fen_pre", 32'(cl_fetch_en_o), 32'd0);
            if (j == 26) chk("t2_fen1", 32'(cl_fetch_en_o), 32'd2);
            if (j == 30) chk("t2_run", 32'(running_o), 32'd1);
        end
        stop_i = 1'b1;
        nxt();
        stop_i = 1'b0;
        nxt();
        chk("t2_idle", 32'(state_o), 32'd0);

        // Scenario 4: drain timeout with cluster 0 stuck busy.
        boot_to_run(2'b11);
        cl_busy_i = 2'b01; stop_i = 1'b1;
        nxt();
        stop_i = 1'b0;
        chk("t4_drain", 32'(state_o), 32'd5);
        n = 1; done = 1'b0;
        for (int i = 0; i < 1200 && !done; i++) begin
            nxt();
            if (state_o == 3'd5) n++;
            else done = 1'b1;
        end
        chk("t4_drain_done", 32'(done), 32'd1);
        chk("t4_drain_len", 32'(n), 32'd1024);
        chk("t4_err", 32'(err_timeout_o), 32'd1);
        chk("t4_dcyc", drain_cycles_o, 32'd1024);
        cl_busy_i = 2'b00;
        repeat (5) nxt();
        chk("t4_err_sticky", 32'(err_timeout_o), 32'd1);
        cl_mask_i = 2'b11; start_i = 1'b1;
        nxt();
        start_i = 1'b0;
        chk("t4_err_clr", 32'(err_timeout_o), 32'd0);

        // Scenario 5: abort on RELEASE cycle 3 (T+19) of the boot just started.
        repeat (18) nxt();
        chk("t5_release", 32'(state_o), 32'd2);
        stop_i = 1'b1;
        nxt();
        stop_i = 1'b0;
        chk("t5_drain", 32'(state_o), 32'd5);
        chk("t5_fen", 32'(cl_fetch_en_o), 32'd0);
        chk("t5_aux", 32'(aux_rst_o), 32'd0);
        nxt();
        chk("t5_idle", 32'(state_o), 32'd0);
        boot_to_run(2'b11);
        cl_mask_i = 2'b01; start_i = 1'b1;
        nxt();
        start_i = 1'b0;
        chk("t5_start_in_run", 32'(state_o), 32'd4);
        stop_i = 1'b1;
        nxt();
        stop_i = 1'b0;
        nxt();
        cl_mask_i = 2'b11; start_i = 1'b1; stop_i = 1'b1;
        nxt();
        start_i = 1'b0; stop_i = 1'b0;
        chk("t5_start_stop", 32'(state_o), 32'd0);

        // Scenario 6: synchronous reset during FETCH, then a zero-mask start.
        cl_mask_i = 2'b11; start_i = 1'b1;
        nxt();
        start_i = 1'b0;
        repeat (25) nxt();
        chk("t6_fetch", 32'(state_o), 32'd3);
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        chk("t6_rst_state", 32'(state_o), 32'd0);
        chk("t6_rst_aux", 32'(aux_rst_o), 32'd1);
        chk("t6_rst_fen", 32'(cl_fetch_en_o), 32'd0);
        cl_mask_i = 2'b00; start_i = 1'b1;
        nxt();
        start_i = 1'b0;
        chk("t6_mask0", 32'(state_o), 32'd0);

        // Randomized traffic, checked against the model every cycle.
        for (int i = 0; i < 5000; i++) begin
            start_i   = ($urandom % 16) == 0;
            stop_i    = ($urandom % 48) == 0;
            cl_mask_i = NC'($urandom);
            cl_eoc_i  = (($urandom % 10) == 0) ? NC'($urandom) : '0;
            cl_busy_i = (($urandom % 3) == 0) ? NC'($urandom) : '0;
            rst_n     = ($urandom % 600) != 0;
            nxt();
        end
        start_i = 1'b0; stop_i = 1'b0; cl_eoc_i = '0; cl_busy_i = '0; rst_n = 1'b1;
        repeat (10) nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
